mult_64b_karatsuba_core: RTL and testbench

//  Pipelined 64x64 -> 128-bit unsigned multiplier, one-level Karatsuba split on 32-bit halves.

---
 rtl/mult_64b_karatsuba_core_pkg.sv | 44 ++++
 rtl/mult_64b_karatsuba_core_mult.sv | 22 ++
 rtl/mult_64b_karatsuba_core.sv | 240 ++++++++++++++++++++++++
 tb/tb_mult_64b_karatsuba_core.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/mult_64b_karatsuba_core_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mult_64b_karatsuba_core_pkg
//  Purpose  : Shared constants, stage payload types and a latency helper for
//             the 64x64 Karatsuba multiplier. A parent that chains this core
//             with the Goldilocks reduction sizes its side/valid delay lines
//             from get_latency() plus IN_PIPE.
//  Contents : HALF_W, FULL_W, LAT_MAX, LAT_PIPE_MH_DEFAULT,
//             preadd_t, pprod_t, get_latency()
//  Revision : 1.0 - initial release
// ============================================================================
package mult_64b_karatsuba_core_pkg;

  localparam int HALF_W  = 32;
  localparam int FULL_W  = 2 * HALF_W;
  localparam int LAT_MAX = 3;

  // bit0 = pre-add register, bit1 = partial-product register, bit2 = output register
  localparam logic [LAT_MAX-1:0] LAT_PIPE_MH_DEFAULT = 3'b111;

  // Pre-add stage payload: operand halves forwarded plus the two 33-bit sums.
  typedef struct packed {
    logic [HALF_W-1:0] a0;
    logic [HALF_W-1:0] a1;
    logic [HALF_W-1:0] b0;
    logic [HALF_W-1:0] b1;
    logic [HALF_W:0]   sa;
    logic [HALF_W:0]   sb;
  } preadd_t;

  // Partial-product stage payload.
  typedef struct packed {
    logic [FULL_W-1:0] z0;
    logic [FULL_W-1:0] z2;
    logic [FULL_W+1:0] zm;
  } pprod_t;

  // Cycles contributed by the internal stages (input register not included).
  function automatic int get_latency(input logic [LAT_MAX-1:0] lat_pipe_mh);
    return $countones(lat_pipe_mh);
  endfunction

endpackage
`default_nettype wire

// File: rtl/mult_64b_karatsuba_core_mult.sv
`default_nettype none
// ============================================================================
//  Module   : mult_33x33_unsigned
//  Purpose  : Combinational 33x33 -> 66-bit unsigned multiply. Used for all
//             three Karatsuba products so each maps onto the same DSP shape.
//  Ports    : i_a [32:0]  operand A
//             i_b [32:0]  operand B
//             o_p [65:0]  exact product
//  Revision : 1.0 - initial release
// ============================================================================
module mult_33x33_unsigned
  import mult_64b_karatsuba_core_pkg::*;
(
  input  logic [HALF_W:0]     i_a,
  input  logic [HALF_W:0]     i_b,
  output logic [2*HALF_W+1:0] o_p
);

  assign o_p = i_a * i_b;

endmodule
`default_nettype wire

// File: rtl/mult_64b_karatsuba_core.sv
`default_nettype none
// ============================================================================
//  Module   : mult_64b_karatsuba_core
//  Purpose  : Pipelined 64x64 -> 128-bit unsigned multiplier using a single
//             Karatsuba split on 32-bit halves. One operation per cycle, no
//             backpressure; valid and sideband ride along with the data.
//  Ports    : clk       clock
//             a_rst     asynchronous reset, active-high
//             in_a/in_b 64-bit unsigned operands
//             in_side   opaque sideband, delayed with the data
//             in_avail  operation valid
//             out_z     128-bit product
//             out_side  sideband of the operation on out_z
//             out_avail out_z/out_side valid
//  Latency  : IN_PIPE + countones(LAT_PIPE_MH)
//  Revision : 1.0 - initial release
// ============================================================================
module mult_64b_karatsuba_core
  import mult_64b_karatsuba_core_pkg::*;
#(
  parameter int                 SIDE_W      = 1,
  parameter int                 IN_PIPE     = 1,
  parameter logic [LAT_MAX-1:0] LAT_PIPE_MH = LAT_PIPE_MH_DEFAULT
) (
  input  logic                clk,
  input  logic                a_rst,
  input  logic [FULL_W-1:0]   in_a,
  input  logic [FULL_W-1:0]   in_b,
  input  logic [SIDE_W-1:0]   in_side,
  input  logic                in_avail,
  output logic [2*FULL_W-1:0] out_z,
  output logic [SIDE_W-1:0]   out_side,
  output logic                out_avail
);

  // --------------------------------------------------------------------------
  // Input stage
  // --------------------------------------------------------------------------
  logic [FULL_W-1:0] w_a;
  logic [FULL_W-1:0] w_b;
  logic [SIDE_W-1:0] w_side;
  logic              w_avail;

  generate
    if (IN_PIPE != 0) begin : g_in_reg
      logic [FULL_W-1:0] r_a;
      logic [FULL_W-1:0] r_b;
      logic [SIDE_W-1:0] r_side;
      logic              r_avail;

      // Data only loads on a valid op, so idle/X inputs never reach the pipe.
      always_ff @(posedge clk or posedge a_rst) begin
        if (a_rst) begin
          r_a     <= '0;
          r_b     <= '0;
          r_side  <= '0;
          r_avail <= 1'b0;
        end else begin
          r_avail <= in_avail;
          if (in_avail) begin
            r_a    <= in_a;
            r_b    <= in_b;
            r_side <= in_side;
          end
        end
      end

      assign w_a     = r_a;
      assign w_b     = r_b;
      assign w_side  = r_side;
      assign w_avail = r_avail;
    end else begin : g_in_comb
      assign w_a     = in_a;
      assign w_b     = in_b;
      assign w_side  = in_side;
      assign w_avail = in_avail;
    end
  endgenerate

  // --------------------------------------------------------------------------
  // S0: pre-add. Sums keep the 33rd bit; a=b=2^64-1 gives 0x1_FFFF_FFFE.
  // --------------------------------------------------------------------------
  preadd_t           w_pre_d;
  preadd_t           w_pre_q;
  logic [SIDE_W-1:0] w_pre_side;
  logic              w_pre_avail;

  always_comb begin
    w_pre_d    = '0;
    w_pre_d.a0 = w_a[HALF_W-1:0];
    w_pre_d.a1 = w_a[FULL_W-1:HALF_W];
    w_pre_d.b0 = w_b[HALF_W-1:0];
    w_pre_d.b1 = w_b[FULL_W-1:HALF_W];
    w_pre_d.sa = {1'b0, w_a[HALF_W-1:0]} + {1'b0, w_a[FULL_W-1:HALF_W]};
    w_pre_d.sb = {1'b0, w_b[HALF_W-1:0]} + {1'b0, w_b[FULL_W-1:HALF_W]};
  end

  generate
    if (LAT_PIPE_MH[0]) begin : g_s0_reg
      preadd_t           r_pre;
      logic [SIDE_W-1:0] r_side;
      logic              r_avail;

      always_ff @(posedge clk or posedge a_rst) begin
        if (a_rst) begin
          r_pre   <= '0;
          r_side  <= '0;
          r_avail <= 1'b0;
        end else begin
          r_avail <= w_avail;
          if (w_avail) begin
            r_pre  <= w_pre_d;
            r_side <= w_side;
          end
        end
      end

      assign w_pre_q     = r_pre;
      assign w_pre_side  = r_side;
      assign w_pre_avail = r_avail;
    end else begin : g_s0_comb
      assign w_pre_q     = w_pre_d;
      assign w_pre_side  = w_side;
      assign w_pre_avail = w_avail;
    end
  endgenerate

  // --------------------------------------------------------------------------
  // S1: three 33x33 products. z0/z2 use zero-extended halves so all three
  // multipliers share one shape.
  // --------------------------------------------------------------------------
  logic [FULL_W+1:0] w_p0;
  logic [FULL_W+1:0] w_p2;
  logic [FULL_W+1:0] w_pm;

  mult_33x33_unsigned u_mult_z0 (
    .i_a ({1'b0, w_pre_q.a0}),
    .i_b ({1'b0, w_pre_q.b0}),
    .o_p (w_p0)
  );

  mult_33x33_unsigned u_mult_z2 (
    .i_a ({1'b0, w_pre_q.a1}),
    .i_b ({1'b0, w_pre_q.b1}),
    .o_p (w_p2)
  );

  mult_33x33_unsigned u_mult_zm (
    .i_a (w_pre_q.sa),
    .i_b (w_pre_q.sb),
    .o_p (w_pm)
  );

  pprod_t            w_pp_d;
  pprod_t            w_pp_q;
  logic [SIDE_W-1:0] w_pp_side;
  logic              w_pp_avail;

  // 32x32 products cannot exceed 64 bits, so the top two bits are always zero.
  always_comb begin
    w_pp_d    = '0;
    w_pp_d.z0 = FULL_W'(w_p0);
    w_pp_d.z2 = FULL_W'(w_p2);
    w_pp_d.zm = w_pm;
  end

  generate
    if (LAT_PIPE_MH[1]) begin : g_s1_reg
      pprod_t            r_pp;
      logic [SIDE_W-1:0] r_side;
      logic              r_avail;

      always_ff @(posedge clk or posedge a_rst) begin
        if (a_rst) begin
          r_pp    <= '0;
          r_side  <= '0;
          r_avail <= 1'b0;
        end else begin
          r_avail <= w_pre_avail;
          if (w_pre_avail) begin
            r_pp   <= w_pp_d;
            r_side <= w_pre_side;
          end
        end
      end

      assign w_pp_q     = r_pp;
      assign w_pp_side  = r_side;
      assign w_pp_avail = r_avail;
    end else begin : g_s1_comb
      assign w_pp_q     = w_pp_d;
      assign w_pp_side  = w_pre_side;
      assign w_pp_avail = w_pre_avail;
    end
  endgenerate

  // --------------------------------------------------------------------------
  // S2: combine. z1 = zm - z0 - z2 = a0*b1 + a1*b0, which is non-negative and
  // fits in 65 bits. The 130-bit sum has its top two bits zero by construction.
  // --------------------------------------------------------------------------
  logic [FULL_W:0]     w_z1;
  logic [2*FULL_W-1:0] w_z_d;

  assign w_z1  = (FULL_W + 1)'(w_pp_q.zm - {2'b00, w_pp_q.z0} - {2'b00, w_pp_q.z2});
  assign w_z_d = (2 * FULL_W)'({2'b00, w_pp_q.z2, {FULL_W{1'b0}}}
                             + {{(HALF_W + 1){1'b0}}, w_z1, {HALF_W{1'b0}}}
                             + {{(FULL_W + 2){1'b0}}, w_pp_q.z0});

  generate
    if (LAT_PIPE_MH[2]) begin : g_s2_reg
      logic [2*FULL_W-1:0] r_z;
      logic [SIDE_W-1:0]   r_side;
      logic                r_avail;

      always_ff @(posedge clk or posedge a_rst) begin
        if (a_rst) begin
          r_z     <= '0;
          r_side  <= '0;
          r_avail <= 1'b0;
        end else begin
          r_avail <= w_pp_avail;
          if (w_pp_avail) begin
            r_z    <= w_z_d;
            r_side <= w_pp_side;
          end
        end
      end

      assign out_z     = r_z;
      assign out_side  = r_side;
      assign out_avail = r_avail;
    end else begin : g_s2_comb
      assign out_z     = w_z_d;
      assign out_side  = w_pp_side;
      assign out_avail = w_pp_avail;
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_mult_64b_karatsuba_core.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mult_64b_karatsuba_core
//  Purpose  : Self-checking bench for mult_64b_karatsuba_core. Sixteen
//             instances cover every IN_PIPE / LAT_PIPE_MH combination and are
//             fed the same stimulus; each owns an expected-result queue.
//             Instance 15 is the default configuration (IN_PIPE=1, 3'b111).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mult_64b_karatsuba_core;
  import mult_64b_karatsuba_core_pkg::*;

  localparam int c_side_w = 4;
  localparam int c_n_cfg  = 16;

  typedef struct packed {
    logic [127:0]         z;
    logic [c_side_w-1:0]  side;
    logic [31:0]          cyc;
  } exp_t;

  logic                clk = 1'b0;
  logic                a_rst;
  logic [63:0]         in_a;
  logic [63:0]         in_b;
  logic [c_side_w-1:0] in_side;
  logic                in_avail;
  logic [31:0]         cyc = 32'd0;

  int n_checks = 0;
  int n_errors = 0;

  exp_t q_exp [c_n_cfg][$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 32'd1;

  task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // --------------------------------------------------------------------------
  // One DUT per configuration, each with its own checker
  // --------------------------------------------------------------------------
  for (genvar k = 0; k < c_n_cfg; k++) begin : g_cfg
    localparam int          c_in  = k / 8;
    localparam logic [2:0]  c_lat = 3'(k % 8);
    localparam int          c_latency = c_in + get_latency(c_lat);

    logic [127:0]         out_z;
    logic [c_side_w-1:0]  out_side;
    logic                 out_avail;
    exp_t                 e;

    mult_64b_karatsuba_core #(
      .SIDE_W      (c_side_w),
      .IN_PIPE     (c_in),
      .LAT_PIPE_MH (c_lat)
    ) u_dut (
      .clk       (clk),
      .a_rst     (a_rst),
      .in_a      (in_a),
      .in_b      (in_b),
      .in_side   (in_side),
      .in_avail  (in_avail),
      .out_z     (out_z),
      .out_side  (out_side),
      .out_avail (out_avail)
    );

    always @(negedge clk) begin
      if (a_rst) begin
        // Any registered configuration is fully cleared; pure comb passes through.
        chk($sformatf("cfg%0d_rst_avail", k), 128'(out_avail),
            (c_latency == 0) ? 128'(in_avail) : 128'd0);
        chk($sformatf("cfg%0d_rst_z", k), out_z,
            (c_latency == 0) ? 128'(in_a) * 128'(in_b) : 128'd0);
      end else if (out_avail) begin
        if (q_exp[k].size() == 0) begin
          chk($sformatf("cfg%0d_spurious_avail", k), 128'(out_avail), 128'd0);
        end else begin
          e = q_exp[k].pop_front();
          chk($sformatf("cfg%0d_z", k), out_z, e.z);
          chk($sformatf("cfg%0d_side", k), 128'(out_side), 128'(e.side));
          chk($sformatf("cfg%0d_latency", k), 128'(cyc - e.cyc), 128'(c_latency));
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Stimulus helpers (called just after a rising edge)
  // --------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [63:0] a, input logic [63:0] b,
                      input logic [c_side_w-1:0] s, input logic [127:0] z);
    in_a     = a;
    in_b     = b;
    in_side  = s;
    in_avail = 1'b1;
    for (int k = 0; k < c_n_cfg; k++) q_exp[k].push_back('{z: z, side: s, cyc: cyc});
    tick();
  endtask

  task automatic send_ref(input logic [63:0] a, input logic [63:0] b, input logic [c_side_w-1:0] s);
    send(a, b, s, 128'(a) * 128'(b));
  endtask

  task automatic idle();
    in_a     = {$urandom, $urandom};
    in_b     = {$urandom, $urandom};
    in_side  = c_side_w'($urandom);
    in_avail = 1'b0;
    tick();
  endtask

  function automatic logic [63:0] rand_op();
    logic [63:0] v;
    case ($urandom_range(0, 7))
      0:       v = 64'd0;
      1:       v = 64'hFFFF_FFFF_FFFF_FFFF;
      2:       v = 64'hFFFF_FFFF_0000_0001;
      3:       v = {32'hFFFF_FFFF, $urandom};
      default: v = {$urandom, $urandom};
    endcase
    return v;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    a_rst    = 1'b1;
    in_a     = '0;
    in_b     = '0;
    in_side  = '0;
    in_avail = 1'b0;
    tick();

    // Reset held with in_avail asserted: nothing may come out.
    for (int i = 0; i < 5; i++) begin
      in_a     = {$urandom, $urandom};
      in_b     = {$urandom, $urandom};
      in_side  = c_side_w'($urandom);
      in_avail = 1'b1;
      tick();
    end
    a_rst = 1'b0;

    // Directed cases with hand-derived results
    send(64'h0000_0001_0000_0000, 64'h0000_0001_0000_0000, 4'h1,
         128'h0000_0000_0000_0001_0000_0000_0000_0000);
    send(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 4'h2,
         128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001);
    send(64'hFFFF_FFFF_0000_0001, 64'd2, 4'h5,
         128'h0000_0000_0000_0001_FFFF_FFFE_0000_0002);
    send(64'd0, 64'hDEAD_BEEF_CAFE_F00D, 4'h3, 128'd0);
    send(64'h1234_5678_9ABC_DEF0, 64'd0, 4'h4, 128'd0);
    for (int i = 0; i < 6; i++) idle();

    // Back-to-back random ops with random gaps
    for (int i = 0; i < 1000; i++) begin
      if ($urandom_range(0, 3) == 0) idle();
      send_ref(rand_op(), rand_op(), c_side_w'($urandom));
    end
    for (int i = 0; i < 6; i++) idle();

    // Reset pulse with three ops in flight: they must all vanish.
    send_ref(64'd7, 64'd9, 4'hA);
    send_ref(64'd11, 64'd13, 4'hB);
    send_ref(64'd17, 64'd19, 4'hC);
    in_avail = 1'b0;
    a_rst    = 1'b1;
    for (int k = 0; k < c_n_cfg; k++) q_exp[k].delete();
    tick();
    a_rst = 1'b0;
    send(64'd3, 64'd5, 4'h6, 128'd15);

    // Drain and confirm every issued op came out
    for (int i = 0; i < 10; i++) idle();
    for (int k = 0; k < c_n_cfg; k++)
      chk($sformatf("cfg%0d_drain", k), 128'(q_exp[k].size()), 128'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
